// File: rtl/acc_cpu_param_if.sv
// Memory/debug bus of the accumulator CPU.
// The CPU is the master; system memory and the test harness sit on the slave side.
interface acc_cpu_param_if #(
  parameter int ADR_W = 5
);
  localparam int DATA_W = ADR_W + 3;

  logic [ADR_W-1:0]  adr_bus;
  logic              rd_mem;
  logic              wr_mem;
  logic              mem_ready;
  logic [DATA_W-1:0] data_bus_in;
  logic [DATA_W-1:0] data_bus_out;
  logic [DATA_W-1:0] acc;
  logic              halted;

  modport master (
    output adr_bus, rd_mem, wr_mem, data_bus_out, acc, halted,
    input  mem_ready, data_bus_in
  );

  modport slave (
    input  adr_bus, rd_mem, wr_mem, data_bus_out, acc, halted,
    output mem_ready, data_bus_in
  );
endinterface

// File: rtl/acc_cpu_param.sv
// Parametrised accumulator CPU: 8-instruction set, zero/carry flags, conditional jump,
// halt, and a ready handshake so memories may insert wait states.
module acc_cpu_param #(
  parameter int ADR_W = 5
) (
  input logic             clk,
  input logic             reset,
  acc_cpu_param_if.master bus
);
  localparam int DATA_W = ADR_W + 3;

  typedef enum logic [2:0] {S_RST, S_FETCH, S_DECODE, S_EXEC, S_HALT} state_e;
  typedef enum logic [2:0] {
    OP_LDA = 3'd0, OP_STA = 3'd1, OP_ADD = 3'd2, OP_SUB = 3'd3,
    OP_AND = 3'd4, OP_JMP = 3'd5, OP_JZ  = 3'd6, OP_HLT = 3'd7
  } op_e;

  state_e            state_q, state_d;
  logic [ADR_W-1:0]  pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] ac_q, ac_d;
  logic              z_q, z_d;
  logic              c_q, c_d;

  op_e               irOp;
  logic [ADR_W-1:0]  irAdr;
  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   diff;

  assign irOp  = op_e'(ir_q[DATA_W-1 -: 3]);
  assign irAdr = ir_q[ADR_W-1:0];
  // The extra top bit of the difference is the borrow, i.e. AC < din.
  assign sum   = {1'b0, ac_q} + {1'b0, bus.data_bus_in};
  assign diff  = {1'b0, ac_q} - {1'b0, bus.data_bus_in};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_RST;
      pc_q    <= '0;
      ir_q    <= '0;
      ac_q    <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      ac_q    <= ac_d;
      z_q     <= z_d;
      c_q     <= c_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    ir_d             = ir_q;
    ac_d             = ac_q;
    z_d              = z_q;
    c_d              = c_q;
    bus.adr_bus      = pc_q;
    bus.rd_mem       = 1'b0;
    bus.wr_mem       = 1'b0;
    bus.data_bus_out = '0;
    bus.acc          = ac_q;
    bus.halted       = 1'b0;

    case (state_q)
      S_RST: state_d = S_FETCH;

      S_FETCH: begin
        bus.rd_mem = 1'b1;
        if (bus.mem_ready) begin
          ir_d    = bus.data_bus_in;
          pc_d    = pc_q + 1'b1;
          state_d = S_DECODE;
        end
      end

      // Jumps and halt finish here; a JZ not taken keeps the already incremented PC.
      S_DECODE: begin
        case (irOp)
          OP_JMP: begin
            pc_d    = irAdr;
            state_d = S_FETCH;
          end
          OP_JZ: begin
            if (z_q) pc_d = irAdr;
            state_d = S_FETCH;
          end
          OP_HLT:  state_d = S_HALT;
          default: state_d = S_EXEC;
        endcase
      end

      S_EXEC: begin
        bus.adr_bus = irAdr;
        if (irOp == OP_STA) begin
          bus.wr_mem       = 1'b1;
          bus.data_bus_out = ac_q;
        end else begin
          bus.rd_mem = 1'b1;
        end
        if (bus.mem_ready) begin
          state_d = S_FETCH;
          case (irOp)
            OP_LDA:  ac_d = bus.data_bus_in;
            OP_ADD:  {c_d, ac_d} = sum;
            OP_SUB: begin
              ac_d = diff[DATA_W-1:0];
              c_d  = diff[DATA_W];
            end
            OP_AND:  ac_d = ac_q & bus.data_bus_in;
            default: ;
          endcase
          if (irOp != OP_STA) z_d = (ac_d == '0);
        end
      end

      S_HALT: bus.halted = 1'b1;

      default: state_d = S_RST;
    endcase
  end
endmodule

// File: tb/tb_acc_cpu_param.sv
// Self-checking bench for acc_cpu_param: an instruction-level model of the CPU predicts
// every bus cycle, plus directed programs with hand-computed results.
module tb_acc_cpu_param;
  localparam int ADR_W  = 5;
  localparam int DATA_W = ADR_W + 3;
  localparam int MEM_N  = 1 << ADR_W;
  localparam int MASK   = (1 << DATA_W) - 1;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  acc_cpu_param_if #(.ADR_W(ADR_W)) bus ();

  acc_cpu_param #(.ADR_W(ADR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] mem      [MEM_N];
  logic [DATA_W-1:0] modelMem [MEM_N];

  int mPc, mAc, mOp, mAdr, mDecodeAdr;
  bit mZ, mC, mInExec, mExpectIdle, mHaltPend, mHalted;
  int checks = 0;
  int errors = 0;

  task automatic checkEq(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compares every DUT output against what the instruction-level model says this cycle must show.
  task automatic checkOutput();
    checkEq("rd_wr_exclusive", int'(bus.rd_mem & bus.wr_mem), 0);
    if (!bus.wr_mem) checkEq("dout_idle", int'(bus.data_bus_out), 0);
    checkEq("acc", int'(bus.acc), mAc);
    if (mExpectIdle) begin
      checkEq("decode_strobes", int'({bus.rd_mem, bus.wr_mem}), 0);
      checkEq("decode_adr", int'(bus.adr_bus), mDecodeAdr);
      checkEq("decode_halted", int'(bus.halted), 0);
    end else if (mHalted) begin
      checkEq("halt_flag", int'(bus.halted), 1);
      checkEq("halt_strobes", int'({bus.rd_mem, bus.wr_mem}), 0);
      checkEq("halt_adr", int'(bus.adr_bus), mPc);
    end else begin
      checkEq("run_halted", int'(bus.halted), 0);
      if (mInExec && mOp == 1) begin
        checkEq("sta_strobes", int'({bus.rd_mem, bus.wr_mem}), 1);
        checkEq("sta_adr", int'(bus.adr_bus), mAdr);
        checkEq("sta_data", int'(bus.data_bus_out), mAc);
      end else if (mInExec) begin
        checkEq("exec_strobes", int'({bus.rd_mem, bus.wr_mem}), 2);
        checkEq("exec_adr", int'(bus.adr_bus), mAdr);
      end else begin
        checkEq("fetch_strobes", int'({bus.rd_mem, bus.wr_mem}), 2);
        checkEq("fetch_adr", int'(bus.adr_bus), mPc);
      end
    end
  endtask

  task automatic modelComplete();
    int instr, op, a, d, s;
    if (!mInExec) begin
      instr       = int'(modelMem[mPc]);
      op          = instr >> ADR_W;
      a           = instr % MEM_N;
      mPc         = (mPc + 1) % MEM_N;
      mDecodeAdr  = mPc;
      mExpectIdle = 1'b1;
      case (op)
        5: mPc = a;
        6: if (mZ) mPc = a;
        7: mHaltPend = 1'b1;
        default: begin
          mInExec = 1'b1;
          mOp     = op;
          mAdr    = a;
        end
      endcase
    end else begin
      mInExec = 1'b0;
      d = int'(modelMem[mAdr]);
      case (mOp)
        0: mAc = d;
        1: modelMem[mAdr] = DATA_W'(mAc);
        2: begin
          s   = mAc + d;
          mC  = (s > MASK);
          mAc = s & MASK;
        end
        3: begin
          mC  = (mAc < d);
          mAc = (mAc - d) & MASK;
        end
        default: mAc = mAc & d;
      endcase
      if (mOp != 1) mZ = (mAc == 0);
    end
  endtask

  // One negedge per cycle: check outputs, then act as the memory with the given ready probability.
  task automatic applyStimulus(input int cycles, input int readyPct);
    bit rdy;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      checkOutput();
      rdy = ($urandom_range(1, 100) <= readyPct);
      bus.mem_ready   = rdy;
      bus.data_bus_in = rdy ? mem[bus.adr_bus] : DATA_W'($urandom);
      if (mExpectIdle) begin
        mExpectIdle = 1'b0;
        if (mHaltPend) begin
          mHaltPend = 1'b0;
          mHalted   = 1'b1;
        end
      end else if (!mHalted && rdy) begin
        modelComplete();
      end
      if (rdy && bus.wr_mem) mem[bus.adr_bus] = bus.data_bus_out;
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    bus.mem_ready   = 1'b0;
    bus.data_bus_in = '0;
    #1;
    checkEq("rst_adr", int'(bus.adr_bus), 0);
    checkEq("rst_rd", int'(bus.rd_mem), 0);
    checkEq("rst_wr", int'(bus.wr_mem), 0);
    checkEq("rst_dout", int'(bus.data_bus_out), 0);
    checkEq("rst_acc", int'(bus.acc), 0);
    checkEq("rst_halted", int'(bus.halted), 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkEq("rst_release_no_rd", int'(bus.rd_mem), 0);
    modelMem = mem;
    mPc = 0; mAc = 0; mOp = 0; mAdr = 0; mDecodeAdr = 0;
    mZ = 0; mC = 0; mInExec = 0; mExpectIdle = 0; mHaltPend = 0; mHalted = 0;
  endtask

  task automatic clearMem();
    for (int i = 0; i < MEM_N; i++) mem[i] = '0;
  endtask

  task automatic runToHalt(input int budget, input int readyPct, output int cycles);
    cycles = 0;
    while (cycles < budget) begin
      applyStimulus(1, readyPct);
      cycles++;
      if (bus.halted) break;
    end
    checkEq("halt_reached", int'(bus.halted), 1);
  endtask

  initial begin
    int n, strobes, op;
    bus.mem_ready   = 1'b0;
    bus.data_bus_in = '0;

    // Reset abandons a stalled STA mid-execute.
    clearMem();
    mem[0] = 8'h25;
    doReset();
    applyStimulus(1, 100);
    applyStimulus(1, 0);
    applyStimulus(2, 0);
    checkEq("t1_wr_before_reset", int'(bus.wr_mem), 1);
    doReset();
    applyStimulus(1, 0);
    checkEq("t1_fetch_adr", int'(bus.adr_bus), 0);
    checkEq("t1_fetch_rd", int'(bus.rd_mem), 1);

    // LDA/ADD/STA/HLT with zero wait states.
    clearMem();
    mem[0] = 8'h0A; mem[1] = 8'h4B; mem[2] = 8'h2C; mem[3] = 8'hE0;
    mem[10] = 8'hF0; mem[11] = 8'h20;
    doReset();
    runToHalt(60, 100, n);
    checkEq("t2_halt_cycles", n - 1, 11);
    checkEq("t2_mem12", int'(mem[12]), 8'h10);
    checkEq("t2_acc", int'(bus.acc), 8'h10);

    // Three wait states in both fetch and execute.
    clearMem();
    mem[0] = 8'h0A; mem[1] = 8'hE0; mem[10] = 8'h55;
    doReset();
    applyStimulus(3, 0);
    checkEq("t3_fetch_hold_adr", int'(bus.adr_bus), 0);
    checkEq("t3_fetch_hold_rd", int'(bus.rd_mem), 1);
    applyStimulus(1, 100);
    applyStimulus(1, 0);
    applyStimulus(3, 0);
    checkEq("t3_exec_hold_adr", int'(bus.adr_bus), 10);
    checkEq("t3_exec_hold_acc", int'(bus.acc), 0);
    applyStimulus(1, 100);
    applyStimulus(1, 0);
    checkEq("t3_acc", int'(bus.acc), 8'h55);
    checkEq("t3_next_fetch", int'(bus.adr_bus), 1);

    // SUB to zero makes JZ taken; one less makes it fall through.
    clearMem();
    mem[0] = 8'h14; mem[1] = 8'h74; mem[2] = 8'hC7; mem[3] = 8'hE0; mem[7] = 8'hE0;
    mem[20] = 8'h33; mem[21] = 8'h32;
    doReset();
    runToHalt(60, 100, n);
    checkEq("t4_taken_acc", int'(bus.acc), 0);
    checkEq("t4_taken_pc", int'(bus.adr_bus), 8);
    mem[1] = 8'h75;
    doReset();
    runToHalt(60, 100, n);
    checkEq("t4_fall_acc", int'(bus.acc), 1);
    checkEq("t4_fall_pc", int'(bus.adr_bus), 4);

    // 05-06 borrows to FF, FF+01 wraps to 00 and sets Z, so JZ is taken.
    clearMem();
    mem[0] = 8'h14; mem[1] = 8'h75; mem[2] = 8'h56; mem[3] = 8'hC6; mem[4] = 8'hE0; mem[6] = 8'hE0;
    mem[20] = 8'h05; mem[21] = 8'h06; mem[22] = 8'h01;
    doReset();
    applyStimulus(6, 100);
    applyStimulus(1, 0);
    checkEq("t5_borrow_acc", int'(bus.acc), 8'hFF);
    runToHalt(60, 100, n);
    checkEq("t5_carry_acc", int'(bus.acc), 0);
    checkEq("t5_jz_pc", int'(bus.adr_bus), 7);

    // PC wraps from the top address to 0, and HLT stays quiet.
    clearMem();
    mem[0] = 8'hBF; mem[31] = 8'h0A; mem[10] = 8'h5A;
    doReset();
    applyStimulus(6, 100);
    checkEq("t6_wrap_adr", int'(bus.adr_bus), 0);
    checkEq("t6_wrap_rd", int'(bus.rd_mem), 1);
    checkEq("t6_wrap_acc", int'(bus.acc), 8'h5A);
    clearMem();
    mem[0] = 8'hE0;
    doReset();
    runToHalt(20, 100, n);
    strobes = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, 50);
      strobes += int'(bus.rd_mem) + int'(bus.wr_mem);
    end
    checkEq("t6_halt_quiet", strobes, 0);
    checkEq("t6_halt_pc", int'(bus.adr_bus), 1);

    // Random programs with random wait states; HLT kept rare so most runs stay busy.
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < MEM_N; i++) begin
        op = $urandom_range(0, 7);
        if (op == 7 && $urandom_range(0, 3) != 0) op = $urandom_range(0, 6);
        if ($urandom_range(0, 3) == 0) mem[i] = DATA_W'($urandom_range(0, 3));
        else mem[i] = DATA_W'((op << ADR_W) | $urandom_range(0, MEM_N - 1));
      end
      doReset();
      applyStimulus(300, 70);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
